// File: rtl/uart_alu_bridge.sv
// Frame sequencer between a byte-wide UART and an ALU: collects multi-byte operands and an
// opcode, presents them to the ALU, then streams the result and an optional status byte back out.
module uart_alu_bridge #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 16,
  parameter int OPC_W       = 6,
  parameter int TIMEOUT     = 100000,
  parameter int SEND_STATUS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  input  logic [OP_W-1:0]   alu_res,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [OP_W-1:0]   a,
  output logic [OP_W-1:0]   b,
  output logic [OPC_W-1:0]  op,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int NB    = OP_W / DATA_W;
  localparam int NTX   = NB + ((SEND_STATUS != 0) ? 1 : 0);
  localparam int IW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int TXW   = (NTX > 1) ? $clog2(NTX) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam logic [IW-1:0]  IDX_LAST = IW'(NB - 1);
  localparam logic [TXW-1:0] TX_LAST  = TXW'(NTX - 1);
  localparam logic [TW-1:0]  T_LAST   = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    RX_A    = 3'd0,
    RX_B    = 3'd1,
    RX_OP   = 3'd2,
    EXEC    = 3'd3,
    TX_LOAD = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  state_t                    state_r;
  logic [IW-1:0]             idx_r;
  logic [TXW-1:0]            tx_idx_r;
  logic [TW-1:0]             timer_r;
  logic                      rx_prev_r;
  logic                      tx_prev_r;
  logic [NTX*DATA_W-1:0]     txbuf_r;

  logic                      rx_ev_s;
  logic                      tx_ev_s;
  logic                      timing_s;
  logic                      timeout_s;
  logic                      in_busy_s;
  logic [DATA_W-1:0]         status_s;
  logic [TXW-1:0]            tx_next_s;
  logic [DATA_W-1:0]         next_byte_s;

  // Edge detection, timeout qualification and next-byte selection.
  always_comb begin
    rx_ev_s     = rx_done & ~rx_prev_r;
    tx_ev_s     = tx_done & ~tx_prev_r;
    timing_s    = (state_r == RX_B) || (state_r == RX_OP) ||
                  ((state_r == RX_A) && (idx_r != '0));
    in_busy_s   = (state_r == EXEC) || (state_r == TX_LOAD) || (state_r == TX_WAIT);
    status_s    = '0;
    status_s[1:0] = {alu_carry, alu_zero};
    tx_next_s   = tx_idx_r + 1'b1;
    next_byte_s = txbuf_r[tx_next_s*DATA_W +: DATA_W];
    // An arriving byte wins over an expiring timer.
    if (TO_EN) begin
      timeout_s = timing_s && (timer_r == T_LAST) && !rx_ev_s;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Frame sequencer: operand capture, ALU hand-off, result transmission, error handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= RX_A;
      idx_r     <= '0;
      tx_idx_r  <= '0;
      timer_r   <= '0;
      rx_prev_r <= 1'b0;
      tx_prev_r <= 1'b0;
      txbuf_r   <= '0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_prev_r <= rx_done;
      tx_prev_r <= tx_done;
      tx_start  <= 1'b0;
      frame_err <= 1'b0;

      if (rx_ev_s || !timing_s || timeout_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + 1'b1;
      end

      if (in_busy_s && rx_ev_s) begin
        frame_err <= 1'b1;
      end

      if (timeout_s) begin
        frame_err <= 1'b1;
        a         <= '0;
        b         <= '0;
        op        <= '0;
        idx_r     <= '0;
        state_r   <= RX_A;
      end else begin
        case (state_r)
          RX_A: begin
            if (rx_ev_s) begin
              a[idx_r*DATA_W +: DATA_W] <= rx_data;
              if (idx_r == IDX_LAST) begin
                idx_r   <= '0;
                state_r <= RX_B;
              end else begin
                idx_r <= idx_r + 1'b1;
              end
            end
          end
          RX_B: begin
            if (rx_ev_s) begin
              b[idx_r*DATA_W +: DATA_W] <= rx_data;
              if (idx_r == IDX_LAST) begin
                idx_r   <= '0;
                state_r <= RX_OP;
              end else begin
                idx_r <= idx_r + 1'b1;
              end
            end
          end
          RX_OP: begin
            if (rx_ev_s) begin
              op      <= rx_data[OPC_W-1:0];
              busy    <= 1'b1;
              state_r <= EXEC;
            end
          end
          EXEC: begin
            // The first byte goes straight from the ALU so tx_start lands in TX_LOAD.
            txbuf_r[OP_W-1:0] <= alu_res;
            if (NTX > NB) begin
              txbuf_r[NTX*DATA_W-1 -: DATA_W] <= status_s;
            end
            tx_data  <= alu_res[DATA_W-1:0];
            tx_start <= 1'b1;
            tx_idx_r <= '0;
            state_r  <= TX_LOAD;
          end
          TX_LOAD: begin
            state_r <= TX_WAIT;
          end
          TX_WAIT: begin
            if (tx_ev_s) begin
              if (tx_idx_r == TX_LAST) begin
                busy    <= 1'b0;
                state_r <= RX_A;
              end else begin
                tx_idx_r <= tx_next_s;
                tx_data  <= next_byte_s;
                tx_start <= 1'b1;
                state_r  <= TX_LOAD;
              end
            end
          end
          default: begin
            busy    <= 1'b0;
            idx_r   <= '0;
            state_r <= RX_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Directed and randomized frames against a byte-level reference model of the bridge plus ALU.
module tb_uart_alu_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done = 1'b0;
  logic [15:0] alu_res;
  logic        alu_carry;
  logic        alu_zero;
  logic [15:0] a;
  logic [15:0] b;
  logic [5:0]  op;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int tx_lat   = 3;
  int long_pulse = 0;
  int data_chg   = 0;
  int last_ev_cyc = 0;
  logic [7:0] got_q[$];
  int         start_cyc_q[$];
  logic [16:0] alu_w;

  always #5 clk = ~clk;

  uart_alu_bridge #(
    .DATA_W(8), .OP_W(16), .OPC_W(6), .TIMEOUT(50), .SEND_STATUS(1)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .a(a), .b(b), .op(op), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .frame_err(frame_err)
  );

  // Stand-in ALU: 0x20 ADD, 0x21 SUB, 0x24 AND, 0x25 OR, 0x26 XOR.
  always_comb begin
    alu_w = '0;
    case (op)
      6'h20:   alu_w = {1'b0, a} + {1'b0, b};
      6'h21:   alu_w = {1'b0, a} - {1'b0, b};
      6'h24:   alu_w = {1'b0, a & b};
      6'h25:   alu_w = {1'b0, a | b};
      6'h26:   alu_w = {1'b0, a ^ b};
      default: alu_w = '0;
    endcase
    alu_res   = alu_w[15:0];
    alu_carry = alu_w[16];
    alu_zero  = (alu_w[15:0] == 16'h0000);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected {status, result_hi, result_lo} from plain integer arithmetic.
  function automatic logic [23:0] model(input logic [15:0] ea, input logic [15:0] eb,
                                        input logic [5:0] eop);
    int x, y, r, c, z;
    x = int'(ea);
    y = int'(eb);
    c = 0;
    case (eop)
      6'h20: begin r = x + y; if (r > 65535) begin c = 1; r = r - 65536; end end
      6'h21: begin r = x - y; if (r < 0) begin c = 1; r = r + 65536; end end
      6'h24: r = x & y;
      6'h25: r = x | y;
      6'h26: r = x ^ y;
      default: r = 0;
    endcase
    z = (r == 0) ? 1 : 0;
    model = {8'(c * 2 + z), 8'(r / 256), 8'(r % 256)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    else return 8'hxx;
  endfunction

  // UART transmitter model: records each tx_start byte and answers with a tx_done pulse.
  initial begin
    int  pend = 0;
    int  cnt  = 0;
    logic [7:0] held = 8'h00;
    logic start_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (frame_err === 1'b1) fe_cnt++;
      if (reset !== 1'b0) begin
        pend = 0;
        tx_done = 1'b0;
        start_prev = 1'b0;
      end else begin
        if (tx_done) tx_done = 1'b0;
        if (tx_start && start_prev) long_pulse++;
        if (tx_start) begin
          got_q.push_back(tx_data);
          start_cyc_q.push_back(cyc);
          held = tx_data;
          pend = 1;
          cnt  = tx_lat;
        end else if (pend != 0) begin
          if (tx_data !== held) data_chg++;
          if (cnt == 0) begin
            tx_done = 1'b1;
            pend = 0;
          end else begin
            cnt--;
          end
        end
        start_prev = tx_start;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input int hold, input int gap);
    @(posedge clk);
    #1;
    rx_data = d;
    rx_done = 1'b1;
    last_ev_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) @(posedge clk);
  endtask

  task automatic run_frame(input logic [15:0] fa, input logic [15:0] fb, input logic [5:0] fop,
                           input int hold, input int gap, input int inject, input string tag);
    int fe0, op_cyc, ok;
    logic [23:0] e;
    got_q.delete();
    start_cyc_q.delete();
    fe0 = fe_cnt;
    send_byte(fa[7:0], hold, gap);
    send_byte(fa[15:8], hold, gap);
    send_byte(fb[7:0], hold, gap);
    send_byte(fb[15:8], hold, gap);
    send_byte({2'($urandom), fop}, hold, 0);
    op_cyc = last_ev_cyc;
    if (inject != 0) begin
      repeat (4) @(posedge clk);
      send_byte(8'h77, 1, 0);
    end
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (got_q.size() == 3 && busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    e = model(fa, fb, fop);
    check({tag, " complete"}, 32'(ok), 32'd1);
    check({tag, " tx byte0"}, 32'(got_at(0)), 32'(e[7:0]));
    check({tag, " tx byte1"}, 32'(got_at(1)), 32'(e[15:8]));
    check({tag, " tx status"}, 32'(got_at(2)), 32'(e[23:16]));
    check({tag, " reg a"}, 32'(a), 32'(fa));
    check({tag, " reg b"}, 32'(b), 32'(fb));
    check({tag, " reg op"}, 32'(op), 32'(fop));
    check({tag, " busy idle"}, 32'(busy), 32'd0);
    check({tag, " start latency"},
          (start_cyc_q.size() > 0) ? 32'(start_cyc_q[0] - op_cyc) : 32'hFFFF_FFFF, 32'd2);
    check({tag, " frame_err count"}, 32'(fe_cnt - fe0), (inject != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int fe0;
    int ok;
    logic [5:0] ops [5];
    ops[0] = 6'h20; ops[1] = 6'h21; ops[2] = 6'h24; ops[3] = 6'h25; ops[4] = 6'h26;

    reset = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    #23;
    check("reset a", 32'(a), 32'd0);
    check("reset b", 32'(b), 32'd0);
    check("reset op", 32'(op), 32'd0);
    check("reset tx_start", 32'(tx_start), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_frame(16'h1234, 16'h0001, 6'h20, 1, 0, 0, "add basic");
    run_frame(16'hFFFF, 16'h0001, 6'h20, 1, 1, 0, "add wrap");

    // Lone byte followed by silence must abort the frame.
    fe0 = fe_cnt;
    send_byte(8'h34, 1, 0);
    repeat (44) @(posedge clk);
    #1;
    check("timeout early", 32'(fe_cnt - fe0), 32'd0);
    repeat (16) @(posedge clk);
    #1;
    check("timeout pulse", 32'(fe_cnt - fe0), 32'd1);
    check("timeout a", 32'(a), 32'd0);
    check("timeout b", 32'(b), 32'd0);
    check("timeout op", 32'(op), 32'd0);
    run_frame(16'h1234, 16'h0001, 6'h20, 1, 0, 0, "after timeout");

    run_frame(16'h1234, 16'h0001, 6'h20, 10, 0, 0, "held rx_done");
    run_frame(16'h0F0F, 16'h00FF, 6'h24, 1, 40, 0, "slow bytes");
    run_frame(16'h5555, 16'h5555, 6'h26, 2, 0, 0, "xor zero");
    run_frame(16'h0000, 16'h0001, 6'h21, 1, 0, 0, "sub borrow");

    for (int i = 0; i < 8; i++) begin
      run_frame(16'($urandom), 16'($urandom), ops[$urandom_range(0, 4)],
                $urandom_range(1, 4), $urandom_range(0, 3), 0, $sformatf("rand%0d", i));
    end

    tx_lat = 20;
    run_frame(16'h1234, 16'h0001, 6'h20, 1, 0, 1, "drop while busy");
    tx_lat = 3;

    // Reset while a byte is being offered to the transmitter.
    send_byte(8'hCD, 1, 0);
    send_byte(8'hAB, 1, 0);
    send_byte(8'h11, 1, 0);
    send_byte(8'h11, 1, 0);
    send_byte(8'h20, 1, 0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (tx_start === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check("reset-test tx_start seen", 32'(ok), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset tx_start", 32'(tx_start), 32'd0);
    check("midreset a", 32'(a), 32'd0);
    check("midreset b", 32'(b), 32'd0);
    check("midreset op", 32'(op), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_frame(16'h1234, 16'h0001, 6'h20, 1, 0, 0, "after reset");

    check("tx_start single cycle", 32'(long_pulse), 32'd0);
    check("tx_data stable", 32'(data_chg), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
